// File: rtl/fs_pkg.sv
// ---------------------------------------------------------------------------
// fs_pkg: shared definitions for the FAST corner-score engine.
//   PIX_W_DEF  : default pixel / threshold width
//   fs_class_e : per-point classification codes (SIMILAR / DARK / BRIGHT)
//   fs_state_e : engine FSM states
//   clog2      : ceiling log2 helper usable in parameter expressions
// ---------------------------------------------------------------------------
package fs_pkg;

    localparam int unsigned PIX_W_DEF = 8;

    typedef enum logic [1:0] {
        SIMILAR = 2'b00,
        DARK    = 2'b01,
        BRIGHT  = 2'b10
    } fs_class_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DONE
    } fs_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fs_lane_score.sv
// ---------------------------------------------------------------------------
// fs_lane_score: combinational classifier for one circle point.
//   ref_pix  in  PIX_W  reference (centre) pixel
//   adj_pix  in  PIX_W  circle pixel
//   thres    in  PIX_W  threshold
//   cls      out 2      DARK / BRIGHT / SIMILAR
//   contrib  out PIX_W  |ref - adj| - thres when not SIMILAR, else 0
// A difference exactly equal to the threshold is SIMILAR.
// ---------------------------------------------------------------------------
module fs_lane_score
    import fs_pkg::*;
#(
    parameter int unsigned PIX_W = PIX_W_DEF
) (
    input  logic [PIX_W-1:0] ref_pix,
    input  logic [PIX_W-1:0] adj_pix,
    input  logic [PIX_W-1:0] thres,
    output fs_class_e        cls,
    output logic [PIX_W-1:0] contrib
);

    logic [PIX_W-1:0] mag;

    always_comb begin
        cls     = SIMILAR;
        contrib = '0;
        mag     = '0;
        if (ref_pix > adj_pix) begin
            mag = ref_pix - adj_pix;
            if (mag > thres) begin
                cls     = DARK;
                contrib = mag - thres;
            end
        end else begin
            mag = adj_pix - ref_pix;
            if (mag > thres) begin
                cls     = BRIGHT;
                contrib = mag - thres;
            end
        end
    end

endmodule

// File: rtl/fs_score_engine.sv
// ---------------------------------------------------------------------------
// fs_score_engine: multi-cycle FAST corner score.
// Accepts one job (ref, NPTS circle pixels, threshold, corner flag) in IDLE,
// scores LANES points per cycle over NPTS/LANES beats, then presents
// max(bright_sum, dark_sum) saturated to OUT_W bits until taken.
//   clk, rst_n           clock / async active-low reset
//   in_valid / in_ready  job handshake (ready only in IDLE)
//   in_ref, in_adj       reference pixel, circle pixels (point 0 in MSBs)
//   in_thres, in_corner  threshold, detector corner flag
//   flush                synchronous abort to IDLE, discards any result
//   out_valid/out_ready  result handshake
//   out_score, out_wren  saturated score, out_valid & latched corner flag
// ---------------------------------------------------------------------------
module fs_score_engine
    import fs_pkg::*;
#(
    parameter int unsigned PIX_W = PIX_W_DEF,
    parameter int unsigned NPTS  = 16,
    parameter int unsigned LANES = 4,
    parameter int unsigned OUT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PIX_W-1:0]      in_ref,
    input  logic [NPTS*PIX_W-1:0] in_adj,
    input  logic [PIX_W-1:0]      in_thres,
    input  logic                  in_corner,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_score,
    output logic                  out_wren
);

    localparam int unsigned SUM_W  = PIX_W + clog2(NPTS);
    localparam int unsigned BEATS  = NPTS / LANES;
    localparam int unsigned BEAT_W = (BEATS > 1) ? clog2(BEATS) : 1;
    localparam int unsigned CMP_W  = (SUM_W > OUT_W) ? SUM_W : OUT_W;

    if ((NPTS % LANES) != 0) begin : g_bad_lanes
        $error("fs_score_engine: NPTS must be a multiple of LANES");
    end

    fs_state_e             state_q, state_d;
    logic [PIX_W-1:0]      ref_q, ref_d;
    logic [NPTS*PIX_W-1:0] adj_q, adj_d;
    logic [PIX_W-1:0]      thres_q, thres_d;
    logic                  corner_q, corner_d;
    logic [SUM_W-1:0]      sd_q, sd_d;
    logic [SUM_W-1:0]      sb_q, sb_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [OUT_W-1:0]      out_score_q, out_score_d;
    logic                  out_wren_q, out_wren_d;

    fs_class_e        lane_cls     [LANES];
    logic [PIX_W-1:0] lane_contrib [LANES];

    // The latched pixel word is shifted left by one beat's worth of points
    // each ACCUM cycle, so the lanes always read the top LANES pixels
    // instead of using a beat-indexed mux.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        fs_lane_score #(
            .PIX_W (PIX_W)
        ) u_lane (
            .ref_pix (ref_q),
            .adj_pix (adj_q[NPTS*PIX_W-1-g*PIX_W -: PIX_W]),
            .thres   (thres_q),
            .cls     (lane_cls[g]),
            .contrib (lane_contrib[g])
        );
    end

    logic [SUM_W-1:0] sd_add, sb_add;
    logic [SUM_W-1:0] sd_sum, sb_sum;
    logic [SUM_W-1:0] score_raw;
    logic [CMP_W-1:0] score_ext;

    always_comb begin
        sd_add = '0;
        sb_add = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (lane_cls[l] == DARK) begin
                sd_add = sd_add + SUM_W'(lane_contrib[l]);
            end
            if (lane_cls[l] == BRIGHT) begin
                sb_add = sb_add + SUM_W'(lane_contrib[l]);
            end
        end
        sd_sum    = sd_q + sd_add;
        sb_sum    = sb_q + sb_add;
        score_raw = (sb_sum >= sd_sum) ? sb_sum : sd_sum;
        score_ext = CMP_W'(score_raw);
    end

    always_comb begin
        state_d     = state_q;
        ref_d       = ref_q;
        adj_d       = adj_q;
        thres_d     = thres_q;
        corner_d    = corner_q;
        sd_d        = sd_q;
        sb_d        = sb_q;
        beat_d      = beat_q;
        out_valid_d = out_valid_q;
        out_score_d = out_score_q;
        out_wren_d  = out_wren_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    ref_d    = in_ref;
                    adj_d    = in_adj;
                    thres_d  = in_thres;
                    corner_d = in_corner;
                    sd_d     = '0;
                    sb_d     = '0;
                    beat_d   = '0;
                    state_d  = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                sd_d  = sd_sum;
                sb_d  = sb_sum;
                adj_d = adj_q << (LANES * PIX_W);
                if (beat_q == BEAT_W'(BEATS - 1)) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    out_wren_d  = corner_q;
                    if (score_ext > CMP_W'({OUT_W{1'b1}})) begin
                        out_score_d = '1;
                    end else begin
                        out_score_d = OUT_W'(score_ext);
                    end
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    out_wren_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (flush) begin
            state_d     = ST_IDLE;
            beat_d      = '0;
            out_valid_d = 1'b0;
            out_wren_d  = 1'b0;
        end

        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ref_q       <= '0;
            adj_q       <= '0;
            thres_q     <= '0;
            corner_q    <= 1'b0;
            sd_q        <= '0;
            sb_q        <= '0;
            beat_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_score_q <= '0;
            out_wren_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ref_q       <= ref_d;
            adj_q       <= adj_d;
            thres_q     <= thres_d;
            corner_q    <= corner_d;
            sd_q        <= sd_d;
            sb_q        <= sb_d;
            beat_q      <= beat_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_score_q <= out_score_d;
            out_wren_q  <= out_wren_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_score = out_score_q;
    assign out_wren  = out_wren_q;

endmodule

// File: tb/tb_fs_score_engine.sv
// ---------------------------------------------------------------------------
// tb_fs_score_engine: directed, table-driven bench for fs_score_engine with
// default parameters (PIX_W=8, NPTS=16, LANES=4, OUT_W=8), plus hand-written
// sequences for output hold, back-to-back period, mid-job reset and flush.
// ---------------------------------------------------------------------------
module tb_fs_score_engine;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_ref;
    logic [127:0] in_adj;
    logic [7:0]   in_thres;
    logic         in_corner;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_score;
    logic         out_wren;

    always #5 clk = ~clk;

    fs_score_engine #(
        .PIX_W (8),
        .NPTS  (16),
        .LANES (4),
        .OUT_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ref    (in_ref),
        .in_adj    (in_adj),
        .in_thres  (in_thres),
        .in_corner (in_corner),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_score (out_score),
        .out_wren  (out_wren)
    );

    typedef struct {
        string        name;
        logic [7:0]   rf;
        logic [7:0]   th;
        logic         corner;
        logic [127:0] adj;
        int           exp_score;
        int           exp_wren;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // points 0..na-1 = a, next nb = b, remainder = c; point 0 in the MSBs
    function automatic logic [127:0] fill3(input int a, input int na,
                                           input int b, input int nb,
                                           input int c);
        logic [127:0] v;
        logic [7:0]   px;
        v = '0;
        for (int p = 0; p < 16; p++) begin
            if (p < na)           px = 8'(a);
            else if (p < na + nb) px = 8'(b);
            else                  px = 8'(c);
            v[(15 - p) * 8 +: 8] = px;
        end
        return v;
    endfunction

    task automatic drive_job(input vec_t v);
        in_ref    = v.rf;
        in_thres  = v.th;
        in_corner = v.corner;
        in_adj    = v.adj;
        in_valid  = 1'b1;
    endtask

    task automatic scramble_inputs();
        in_ref    = 8'($urandom);
        in_thres  = 8'($urandom);
        in_corner = 1'($urandom);
        in_adj    = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Called #1 after a rising edge; returns #1 after a rising edge.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic release_result(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, " out_valid after take"}, int'(out_valid), 0);
        check({name, " in_ready after take"}, int'(in_ready), 1);
    endtask

    task automatic run_job(input vec_t v);
        int n;
        drive_job(v);
        check({v.name, " in_ready before accept"}, int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble_inputs();
        check({v.name, " in_ready busy"}, int'(in_ready), 0);
        wait_valid(n);
        check({v.name, " latency"}, n, 4);
        check({v.name, " score"}, int'(out_score), v.exp_score);
        check({v.name, " wren"}, int'(out_wren), v.exp_wren);
        release_result(v.name);
    endtask

    task automatic abort_check(input string name);
        int seen;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check({name, " no result after abort"}, seen, 0);
        check({name, " in_ready idle after abort"}, int'(in_ready), 1);
    endtask

    vec_t vecs[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   n;
        int   seen;
        logic pre;
        logic [127:0] ramp;

        vecs[0]  = '{"all_dark_sat",   8'd100, 8'd20, 1'b1, fill3(50, 16, 0, 0, 0),     255, 1};
        vecs[1]  = '{"bright90",       8'd100, 8'd20, 1'b1, fill3(130, 9, 100, 7, 0),   90, 1};
        vecs[2]  = '{"eq_thres",       8'd100, 8'd20, 1'b1, fill3(80, 8, 120, 8, 0),    0, 1};
        vecs[3]  = '{"tie80_nocorner", 8'd100, 8'd20, 1'b0, fill3(60, 4, 140, 4, 100),  80, 0};
        vecs[4]  = '{"max_bright",     8'd0,   8'd0,  1'b1, fill3(255, 16, 0, 0, 0),    255, 1};
        vecs[5]  = '{"big_thres",      8'd200, 8'd250, 1'b0, fill3(0, 8, 255, 8, 0),    0, 0};
        vecs[6]  = '{"dark_wins",      8'd100, 8'd10, 1'b1, fill3(50, 2, 125, 3, 100),  80, 1};
        vecs[7]  = '{"ramp55",         8'd50,  8'd5,  1'b1, '0,                          55, 1};
        vecs[8]  = '{"dark16",         8'd10,  8'd0,  1'b0, fill3(9, 16, 0, 0, 0),      16, 0};
        vecs[9]  = '{"exact255",       8'd100, 8'd0,  1'b1, fill3(83, 15, 100, 1, 0),   255, 1};
        vecs[10] = '{"sat256",         8'd100, 8'd0,  1'b1, fill3(83, 15, 99, 1, 0),    255, 1};
        ramp = '0;
        for (int p = 0; p < 16; p++) ramp[(15 - p) * 8 +: 8] = 8'(50 + p);
        vecs[7].adj = ramp;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_ref    = '0;
        in_adj    = '0;
        in_thres  = '0;
        in_corner = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #12;
        check("reset in_ready", int'(in_ready), 1);
        check("reset out_valid", int'(out_valid), 0);
        check("reset out_score", int'(out_score), 0);
        check("reset out_wren", int'(out_wren), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) run_job(vecs[i]);

        // Output hold while out_ready is low; new job offered but ignored.
        drive_job(vecs[0]);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(n);
        check("hold latency", n, 4);
        check("hold score initial", int'(out_score), 255);
        drive_job(vecs[1]);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("hold out_valid", int'(out_valid), 1);
            check("hold out_score", int'(out_score), 255);
            check("hold out_wren", int'(out_wren), 1);
            check("hold in_ready", int'(in_ready), 0);
        end
        release_result("hold");
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble_inputs();
        check("hold next job accepted", int'(in_ready), 0);
        wait_valid(n);
        check("hold next latency", n, 4);
        check("hold next score", int'(out_score), 90);
        release_result("hold next");

        // Back-to-back jobs with out_ready held high: period BEATS+2.
        drive_job(vecs[1]);
        out_ready = 1'b1;
        @(posedge clk); #1;
        n    = 0;
        seen = 0;
        do begin
            pre = in_ready;
            @(posedge clk); #1;
            n++;
            if (out_valid) seen++;
        end while (!pre && n < 20);
        check("period cycles", n, 6);
        check("period out_valid beats", seen, 1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        scramble_inputs();
        wait_valid(n);
        check("period second latency", n, 4);
        check("period second score", int'(out_score), 90);
        release_result("period");

        // Asynchronous reset during beat 2.
        drive_job(vecs[0]);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst mid out_valid", int'(out_valid), 0);
        check("rst mid in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        abort_check("rst");
        run_job(vecs[1]);

        // Flush during beat 2.
        drive_job(vecs[0]);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush out_valid", int'(out_valid), 0);
        check("flush in_ready", int'(in_ready), 1);
        abort_check("flush");
        run_job(vecs[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fs_score_engine.md
# fs_score_engine

Multi-cycle, parametrised FAST corner-score engine: classifies NPTS circle pixels against a reference pixel and threshold internally, accumulates dark-set and bright-set scores over LANES pixels per cycle, and returns the saturated maximum. It sits between the corner detector (FS_Detect stage) and the score SRAM write port. It adds valid/ready handshakes, output saturation and flush, and can be time-multiplexed by choosing LANES < NPTS.

## Interface
- PIX_W, 8, pixel and threshold width
- NPTS, 16, circle points per job
- LANES, 4, points scored per cycle; NPTS % LANES == 0 (elaboration error otherwise)
- OUT_W, 8, score output width; internal sum width SUM_W = PIX_W + clog2(NPTS)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  job offered
- in_ready  out  1  engine accepts job (IDLE only)
- in_ref  in  PIX_W  reference pixel
- in_adj  in  NPTS*PIX_W  circle pixels, point 0 in MSBs
- in_thres  in  PIX_W  threshold
- in_corner  in  1  corner flag from detector
- flush  in  1  synchronous abort to IDLE
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_score  out  OUT_W  max(bright, dark), saturated
- out_wren  out  1  out_valid & latched corner flag

## Operation
- Classification per point i (unsigned, PIX_W+1 bit intermediate): dark if ref − adj > thres, contribution ref − adj − thres; bright if adj − ref > thres, contribution adj − ref − thres; otherwise similar, contribution 0. |diff| == thres is similar.
- Sums: sD, sB are SUM_W-bit accumulators; no overflow possible by width.
- Score = (sB >= sD) ? sB : sD; if score > 2^OUT_W−1 then out_score = 2^OUT_W−1.
- FSM states IDLE, ACCUM, DONE.
- IDLE: in_ready = 1. On in_valid: latch ref, adj, thres and corner; clear sD, sB and beat counter; go to ACCUM.
- ACCUM: each cycle, add the contributions of points beat*LANES .. beat*LANES+LANES−1 to sD and sB. Beat counter counts 0..BEATS−1 (BEATS = NPTS/LANES). On the last beat, go to DONE.
- DONE: out_valid = 1. out_score and out_wren are registered and held stable while out_ready = 0. On out_ready, go to IDLE.
- flush, any state: go to IDLE at the next edge; any pending result is discarded; out_valid is low after that edge. flush takes priority over in_valid and out_ready.
- in_adj, in_ref, in_thres and in_corner are ignored outside the accept cycle.

## Timing
- Reset: state IDLE, in_ready = 1, out_valid = 0, out_score = 0, out_wren = 0, sD = sB = 0, beat = 0.
- Accept at edge k, beats at edges k+1 .. k+BEATS, out_valid high after edge k+BEATS. Latency is BEATS cycles; with the defaults this is 4.
- With out_ready held high, the minimum job period is BEATS+2 cycles.
- out_score and out_wren are registered outputs with no combinational path from inputs.
- in_ready depends only on state; there is no input-to-in_ready combinational path.
- rst_n assertion mid-job: all state is cleared immediately (asynchronously). No partial result ever appears.

## Structure
- Shared package fs_pkg:
  - PIX_W default
  - class codes SIMILAR = 2'b00, DARK = 2'b01, BRIGHT = 2'b10
  - FSM state enum
  - a clog2 helper
- Sub-module fs_lane_score (combinational): takes ref, adj and thres; outputs the 2-bit class and a PIX_W-bit contribution. It is instantiated LANES times, and the engine adds the per-lane results into the accumulators.

## Test plan
(defaults, LANES = 4)
- ref=100, thres=20, all 16 adj=50 -> sD=480, out_score=255 (saturated); out_valid rises 4 edges after accept; out_wren=in_corner=1.
- ref=100, thres=20, 9 adj=130, 7 adj=100 -> sB=90, sD=0, out_score=90.
- ref=100, thres=20, 8 adj=80, 8 adj=120 (|diff|==thres) -> all similar, out_score=0.
- 4 adj=60, 4 adj=140, 8 adj=100, ref=100, thres=20, corner=0 -> sD=sB=80, out_score=80, out_wren=0.
- out_ready low for 3 cycles in DONE -> out_valid, out_score and out_wren stable, in_ready=0, a new in_valid is ignored; the result is taken when out_ready rises, and the next job is accepted 1 cycle later.
- rst_n low during beat 2, or flush during beat 2 -> out_valid never rises, in_ready=1 afterwards; the following job (case 2) gives out_score=90.
